// File: rtl/alu_op_sequencer.sv
// Initiator front-end for a combinational ALU: screens requests, holds operands
// for a programmable settle time and returns results in order through a FIFO.
module alu_op_sequencer #(
  parameter int WIDTH       = 32,
  parameter int ALU_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int TAG_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  input  logic [3:0]         req_op,
  input  logic [TAG_W-1:0]   req_tag,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [3:0]         alu_opcode,
  input  logic [2*WIDTH-1:0] alu_out,
  input  logic               alu_carry,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_result,
  output logic               rsp_carry,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               rsp_err,
  output logic               busy
);

  localparam int CNT_W  = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    ERROR
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   lat_cnt;
  logic [TAG_W-1:0]   tag_q;
  logic               accept;
  logic               illegal;
  logic               load_alu;
  logic               load_tag;
  logic               push;
  logic               pop;
  logic [2*WIDTH-1:0] push_result;
  logic               push_carry;
  logic               push_err;

  logic [2*WIDTH-1:0] mem_result [FIFO_DEPTH];
  logic               mem_carry  [FIFO_DEPTH];
  logic [TAG_W-1:0]   mem_tag    [FIFO_DEPTH];
  logic               mem_err    [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [FCNT_W-1:0]  count;
  logic               fifo_full;
  logic               fifo_empty;

  assign fifo_full  = (count == FCNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);

  // rst_n gates ready so nothing is offered while the block is held in reset.
  assign req_ready = rst_n && (state == IDLE) && !fifo_full;
  assign accept    = req_valid && req_ready;
  assign illegal   = (req_op > 4'd3) || ((req_op == 4'd3) && (req_b == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    load_alu    = 1'b0;
    load_tag    = 1'b0;
    push        = 1'b0;
    push_result = '0;
    push_carry  = 1'b0;
    push_err    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          load_tag = 1'b1;
          if (illegal) begin
            state_nxt = ERROR;
          end else begin
            load_alu  = 1'b1;
            state_nxt = EXEC;
          end
        end
      end
      EXEC: begin
        if (lat_cnt == '0) begin
          push        = 1'b1;
          push_result = alu_out;
          push_carry  = alu_carry;
          state_nxt   = IDLE;
        end
      end
      ERROR: begin
        push      = 1'b1;
        push_err  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      lat_cnt    <= '0;
      tag_q      <= '0;
    end else begin
      if (load_alu) begin
        alu_a      <= req_a;
        alu_b      <= req_b;
        alu_opcode <= req_op;
        lat_cnt    <= CNT_W'(ALU_LATENCY - 1);
      end else if ((state == EXEC) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
      if (load_tag) begin
        tag_q <= req_tag;
      end
    end
  end

  // Storage needs no reset: the head is masked to zero whenever count is 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr_ptr] <= push_result;
      mem_carry[wr_ptr]  <= push_carry;
      mem_tag[wr_ptr]    <= tag_q;
      mem_err[wr_ptr]    <= push_err;
    end
  end

  assign pop = !fifo_empty && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rsp_valid  = !fifo_empty;
  assign rsp_result = rsp_valid ? mem_result[rd_ptr] : '0;
  assign rsp_carry  = rsp_valid ? mem_carry[rd_ptr]  : 1'b0;
  assign rsp_tag    = rsp_valid ? mem_tag[rd_ptr]    : '0;
  assign rsp_err    = rsp_valid ? mem_err[rd_ptr]    : 1'b0;
  assign busy       = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (settle time 1 and 3) each wired
// to a behavioural ALU; table vectors, corner sequences and random traffic.
module tb_alu_op_sequencer;

  localparam int W     = 32;
  localparam int TW    = 4;
  localparam int DEPTH = 4;

  typedef logic [71:0] chk_t;

  typedef struct {
    logic [3:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [TW-1:0]  tag;
    logic [2*W-1:0] result;
    logic           carry;
    logic           err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic           req_valid  [2];
  logic           req_ready  [2];
  logic [W-1:0]   req_a      [2];
  logic [W-1:0]   req_b      [2];
  logic [3:0]     req_op     [2];
  logic [TW-1:0]  req_tag    [2];
  logic [W-1:0]   alu_a      [2];
  logic [W-1:0]   alu_b      [2];
  logic [3:0]     alu_opcode [2];
  logic [2*W-1:0] alu_out    [2];
  logic           alu_carry  [2];
  logic           rsp_valid  [2];
  logic           rsp_ready  [2];
  logic [2*W-1:0] rsp_result [2];
  logic           rsp_carry  [2];
  logic [TW-1:0]  rsp_tag    [2];
  logic           rsp_err    [2];
  logic           busy       [2];

  // Combinational ALU: {carry, result}. ADD keeps the 33-bit sum in the result.
  function automatic logic [2*W:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [3:0] op);
    logic [W:0] s;
    logic [2*W:0] r;
    r = '0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; r = {s[W], (2*W)'(s)}; end
      4'd1: begin s = {1'b0, a} - {1'b0, b}; r = {s[W], (2*W)'(s[W-1:0])}; end
      4'd2: r = {1'b0, (2*W)'(a) * (2*W)'(b)};
      4'd3: if (b != '0) r = {1'b0, a % b, a / b};
      default: r = '0;
    endcase
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_op_sequencer #(
      .WIDTH(W), .ALU_LATENCY(g == 0 ? 1 : 3), .FIFO_DEPTH(DEPTH), .TAG_W(TW)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_a(req_a[g]), .req_b(req_b[g]), .req_op(req_op[g]), .req_tag(req_tag[g]),
      .alu_a(alu_a[g]), .alu_b(alu_b[g]), .alu_opcode(alu_opcode[g]),
      .alu_out(alu_out[g]), .alu_carry(alu_carry[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
      .rsp_result(rsp_result[g]), .rsp_carry(rsp_carry[g]),
      .rsp_tag(rsp_tag[g]), .rsp_err(rsp_err[g]), .busy(busy[g])
    );
    assign {alu_carry[g], alu_out[g]} = alu_model(alu_a[g], alu_b[g], alu_opcode[g]);
  end

  int n_pass  = 0;
  int n_total = 0;

  logic [W-1:0] exp_a  [2];
  logic [W-1:0] exp_b  [2];
  logic [3:0]   exp_op [2];

  task automatic check(input string name, input chk_t act, input chk_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t expect_rsp(input logic [3:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b, input logic [TW-1:0] tag);
    vec_t e;
    logic [2*W:0] r;
    e.op = op; e.a = a; e.b = b; e.tag = tag;
    if (op > 4'd3 || (op == 4'd3 && b == '0)) begin
      e.result = '0; e.carry = 1'b0; e.err = 1'b1;
    end else begin
      r = alu_model(a, b, op);
      e.result = r[2*W-1:0]; e.carry = r[2*W]; e.err = 1'b0;
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge just after the accept edge.
  task automatic issue(input int d, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [TW-1:0] tag, output bit ok);
    int k;
    req_op[d] = op; req_a[d] = a; req_b[d] = b; req_tag[d] = tag; req_valid[d] = 1'b1;
    k = 0;
    while (!req_ready[d] && k < 50) begin
      @(negedge clk);
      k++;
    end
    ok = req_ready[d];
    @(negedge clk);
    req_valid[d] = 1'b0;
  endtask

  task automatic do_vec(input int d, input vec_t v, input int lat, input string nm);
    bit ok;
    int k, low, exp_lat;
    if (!v.err) begin
      exp_a[d] = v.a; exp_b[d] = v.b; exp_op[d] = v.op;
    end
    exp_lat = v.err ? 1 : lat;
    issue(d, v.op, v.a, v.b, v.tag, ok);
    check({nm, " accept"}, chk_t'(ok), chk_t'(1));
    check({nm, " alu_a"}, chk_t'(alu_a[d]), chk_t'(exp_a[d]));
    check({nm, " alu_b"}, chk_t'(alu_b[d]), chk_t'(exp_b[d]));
    check({nm, " alu_opcode"}, chk_t'(alu_opcode[d]), chk_t'(exp_op[d]));
    k = 0; low = 0;
    while (!rsp_valid[d] && k < 50) begin
      if (!req_ready[d]) low++;
      @(negedge clk);
      k++;
    end
    check({nm, " latency"}, chk_t'(k), chk_t'(exp_lat));
    check({nm, " ready_low"}, chk_t'(low), chk_t'(exp_lat));
    check({nm, " rsp_valid"}, chk_t'(rsp_valid[d]), chk_t'(1));
    check({nm, " rsp_result"}, chk_t'(rsp_result[d]), chk_t'(v.result));
    check({nm, " rsp_carry/tag/err"}, chk_t'({rsp_carry[d], rsp_tag[d], rsp_err[d]}),
          chk_t'({v.carry, v.tag, v.err}));
    check({nm, " ready_back"}, chk_t'(req_ready[d]), chk_t'(1));
    check({nm, " busy_q"}, chk_t'(busy[d]), chk_t'(1));
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    check({nm, " popped"}, chk_t'({rsp_valid[d], busy[d], rsp_result[d]}), chk_t'(0));
  endtask

  task automatic rand_run(input int d, input int cycles, input bit stream);
    vec_t q[$];
    vec_t e;
    int viol;
    bit prev_v;
    logic [3:0] op;
    viol = 0; prev_v = 1'b0;
    for (int c = 0; c < cycles + 60; c++) begin
      if (c < cycles) begin
        op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
        req_op[d]  = op;
        req_a[d]   = $urandom;
        req_b[d]   = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
        req_tag[d] = TW'($urandom);
        req_valid[d] = stream ? 1'b1 : 1'($urandom_range(0, 1));
        rsp_ready[d] = stream ? 1'b1 : ($urandom_range(0, 3) != 0);
      end else begin
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
      end
      if (rsp_valid[d] && rsp_ready[d]) begin
        if (q.size() == 0) begin
          check("rand unexpected rsp", chk_t'(1), chk_t'(0));
        end else begin
          e = q.pop_front();
          check("rand rsp", chk_t'({rsp_result[d], rsp_carry[d], rsp_tag[d], rsp_err[d]}),
                chk_t'({e.result, e.carry, e.tag, e.err}));
        end
      end
      if (req_valid[d] && req_ready[d])
        q.push_back(expect_rsp(req_op[d], req_a[d], req_b[d], req_tag[d]));
      if (stream && rsp_valid[d] && prev_v) viol++;
      prev_v = rsp_valid[d];
      @(negedge clk);
    end
    check("rand drained", chk_t'(q.size()), chk_t'(0));
    check("rand idle", chk_t'({rsp_valid[d], busy[d]}), chk_t'(0));
    if (stream) check("stream pop same cycle", chk_t'(viol), chk_t'(0));
    rsp_ready[d] = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[9];
    bit ok;
    int acc, got;

    tbl[0] = '{4'd0, 32'hFFFF_FFFF, 32'd1, 4'd3, 64'h0000_0001_0000_0000, 1'b1, 1'b0};
    tbl[1] = '{4'd2, 32'h0001_0000, 32'h0001_0000, 4'd7, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
    tbl[2] = '{4'd1, 32'd5, 32'd7, 4'd2, 64'h0000_0000_FFFF_FFFE, 1'b1, 1'b0};
    tbl[3] = '{4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd8, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b0};
    tbl[4] = '{4'd3, 32'd100, 32'd7, 4'd9, 64'h0000_0002_0000_000E, 1'b0, 1'b0};
    tbl[5] = '{4'd3, 32'd7, 32'd0, 4'd5, 64'h0, 1'b0, 1'b1};
    tbl[6] = '{4'd9, 32'd1, 32'd2, 4'd6, 64'h0, 1'b0, 1'b1};
    tbl[7] = '{4'd0, 32'd2, 32'd3, 4'd1, 64'h0000_0000_0000_0005, 1'b0, 1'b0};
    tbl[8] = '{4'd4, 32'd12, 32'd0, 4'd15, 64'h0, 1'b0, 1'b1};

    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; rsp_ready[d] = 1'b0;
      req_a[d] = '0; req_b[d] = '0; req_op[d] = '0; req_tag[d] = '0;
      exp_a[d] = '0; exp_b[d] = '0; exp_op[d] = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset ready", chk_t'(req_ready[d]), chk_t'(0));
      check("reset outputs", chk_t'({rsp_valid[d], busy[d], rsp_result[d], rsp_carry[d],
            rsp_tag[d], rsp_err[d]}), chk_t'(0));
      check("reset alu", chk_t'({alu_a[d], alu_b[d], alu_opcode[d]}), chk_t'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) check("ready after reset", chk_t'(req_ready[d]), chk_t'(1));

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 9; i++)
        do_vec(d, tbl[i], d == 0 ? 1 : 3, $sformatf("vec%0d.%0d", d, i));

    // Backpressure: six SUBs (results 10..15) against a stalled response port.
    rsp_ready[0] = 1'b0; acc = 0;
    for (int c = 0; c < 20; c++) begin
      req_valid[0] = (acc < 6);
      req_op[0] = 4'd1; req_a[0] = W'(acc + 11); req_b[0] = 32'd1; req_tag[0] = TW'(acc);
      if (req_valid[0] && req_ready[0]) acc++;
      @(negedge clk);
    end
    check("bp accepted", chk_t'(acc), chk_t'(4));
    check("bp full", chk_t'({req_ready[0], rsp_valid[0], busy[0], rsp_tag[0]}),
          chk_t'({1'b0, 1'b1, 1'b1, 4'd0}));
    rsp_ready[0] = 1'b1; got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      req_valid[0] = (acc < 6);
      req_op[0] = 4'd1; req_a[0] = W'(acc + 11); req_b[0] = 32'd1; req_tag[0] = TW'(acc);
      if (rsp_valid[0]) begin
        check("bp result", chk_t'(rsp_result[0]), chk_t'(got + 10));
        check("bp tag/err", chk_t'({rsp_tag[0], rsp_err[0], rsp_carry[0]}),
              chk_t'({TW'(got), 2'b00}));
        got++;
      end
      if (req_valid[0] && req_ready[0]) acc++;
      @(negedge clk);
    end
    req_valid[0] = 1'b0; rsp_ready[0] = 1'b0;
    check("bp returned", chk_t'(got), chk_t'(6));
    check("bp all accepted", chk_t'(acc), chk_t'(6));
    @(negedge clk);

    // Reset while EXEC with two responses queued.
    issue(0, 4'd0, 32'd1, 32'd1, 4'd1, ok);
    issue(0, 4'd0, 32'd2, 32'd2, 4'd2, ok);
    issue(0, 4'd0, 32'd4, 32'd4, 4'd4, ok);
    check("pre-reset busy", chk_t'({busy[0], rsp_valid[0], req_ready[0]}), chk_t'(3'b110));
    rst_n = 1'b0;
    #1;
    check("mid reset rsp", chk_t'({rsp_valid[0], busy[0], req_ready[0]}), chk_t'(0));
    check("mid reset alu", chk_t'({alu_a[0], alu_b[0], alu_opcode[0]}), chk_t'(0));
    for (int d = 0; d < 2; d++) begin
      exp_a[d] = '0; exp_b[d] = '0; exp_op[d] = '0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_vec(0, tbl[7], 1, "post-reset add");

    rand_run(0, 300, 1'b1);
    rand_run(0, 1500, 1'b0);
    rand_run(1, 300, 1'b1);
    rand_run(1, 1500, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
